// File: rtl/datapath_sequencer.sv
// Multicycle fetch/decode/memory/writeback sequencer for a shared memory port.
// It raises the request strobes, gates the architectural write enables, and
// keeps the halt/error flags and the saturating performance counters.
module datapath_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             cu_dREN,
    input  logic             cu_dWEN,
    input  logic             cu_regWrite,
    input  logic             cu_halt,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             instrEN,
    output logic             pcEN,
    output logic             regWEN,
    output logic             halt,
    output logic             err,
    output logic [CNT_W-1:0] cyc_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t            state_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic              dren_reg;
    logic              dwen_reg;
    logic              regwrite_reg;
    logic              err_reg;
    logic [CNT_W-1:0]  cyc_reg;
    logic [CNT_W-1:0]  instr_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= IDLE;
            wait_reg     <= '0;
            dren_reg     <= 1'b0;
            dwen_reg     <= 1'b0;
            regwrite_reg <= 1'b0;
            err_reg      <= 1'b0;
            cyc_reg      <= '0;
            instr_reg    <= '0;
        end else begin
            if (state_reg != IDLE && state_reg != HALT && cyc_reg != '1)
                cyc_reg <= cyc_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    wait_reg  <= '0;
                    state_reg <= FETCH;
                end
                FETCH: begin
                    // A hit in the last allowed cycle still wins over the timeout.
                    if (ihit) begin
                        state_reg <= DECODE;
                    end else if (wait_reg == WAIT_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= HALT;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                DECODE: begin
                    dren_reg     <= cu_dREN;
                    dwen_reg     <= cu_dWEN;
                    regwrite_reg <= cu_regWrite;
                    wait_reg     <= '0;
                    if (cu_halt) begin
                        state_reg <= HALT;
                    end else if (cu_dREN && cu_dWEN) begin
                        err_reg   <= 1'b1;
                        state_reg <= HALT;
                    end else if (cu_dREN || cu_dWEN) begin
                        state_reg <= MEM;
                    end else begin
                        state_reg <= WB;
                    end
                end
                MEM: begin
                    if (dhit) begin
                        state_reg <= WB;
                    end else if (wait_reg == WAIT_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= HALT;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                WB: begin
                    if (instr_reg != '1)
                        instr_reg <= instr_reg + 1'b1;
                    wait_reg  <= '0;
                    state_reg <= FETCH;
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Decoded straight from state so an asynchronous reset drops them at once.
    assign imemREN     = (state_reg == FETCH);
    assign instrEN     = (state_reg == FETCH) & ihit;
    assign dmemREN     = (state_reg == MEM) & dren_reg;
    assign dmemWEN     = (state_reg == MEM) & dwen_reg;
    assign pcEN        = (state_reg == WB);
    assign regWEN      = (state_reg == WB) & regwrite_reg;
    assign halt        = (state_reg == HALT);
    assign err         = err_reg;
    assign cyc_count   = cyc_reg;
    assign instr_count = instr_reg;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: a short-timeout instance for the
// sequencing scenarios and a narrow-counter instance for saturation.
module tb_datapath_sequencer;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst, ihit, dhit, cu_dren, cu_dwen, cu_regwrite, cu_halt;
    logic imemren, dmemren, dmemwen, instren, pcen, regwen, halt, err;
    logic [31:0] cyc_count, instr_count;

    logic s_nrst;
    logic s_one  = 1'b1;
    logic s_zero = 1'b0;
    logic s_imem, s_dren, s_dwen, s_instr, s_pc, s_regw, s_halt, s_err;
    logic [2:0] s_cyc, s_instr_cnt;

    datapath_sequencer #(.CNT_W(32), .TIMEOUT(TO)) dut (
        .CLK(clk), .nRST(nrst), .ihit(ihit), .dhit(dhit),
        .cu_dREN(cu_dren), .cu_dWEN(cu_dwen), .cu_regWrite(cu_regwrite), .cu_halt(cu_halt),
        .imemREN(imemren), .dmemREN(dmemren), .dmemWEN(dmemwen), .instrEN(instren),
        .pcEN(pcen), .regWEN(regwen), .halt(halt), .err(err),
        .cyc_count(cyc_count), .instr_count(instr_count)
    );

    datapath_sequencer #(.CNT_W(3), .TIMEOUT(TO)) dut_sat (
        .CLK(clk), .nRST(s_nrst), .ihit(s_one), .dhit(s_zero),
        .cu_dREN(s_zero), .cu_dWEN(s_zero), .cu_regWrite(s_one), .cu_halt(s_zero),
        .imemREN(s_imem), .dmemREN(s_dren), .dmemWEN(s_dwen), .instrEN(s_instr),
        .pcEN(s_pc), .regWEN(s_regw), .halt(s_halt), .err(s_err),
        .cyc_count(s_cyc), .instr_count(s_instr_cnt)
    );

    typedef struct {
        logic regw;
        int   cyc;
        int   instr;
    } exp_t;

    exp_t sb[$];
    int vectors    = 0;
    int miscompares = 0;
    int exp_cyc    = 0;
    int exp_instr  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic garbage_cu();
        cu_dren = 1'b1; cu_dwen = 1'b1; cu_regwrite = 1'b1; cu_halt = 1'b1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        ihit = 1'b0; dhit = 1'b0;
        cu_dren = 1'b0; cu_dwen = 1'b0; cu_regwrite = 1'b0; cu_halt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outs", {24'd0, imemren, dmemren, dmemwen, instren, pcen, regwen, halt, err}, 32'd0);
        check("rst_cyc", cyc_count | instr_count, 32'd0);
        nrst = 1'b1;
        check("idle_imem", {31'd0, imemren}, 32'd0);
        @(negedge clk);
        exp_cyc = 0;
        exp_instr = 0;
        sb.delete();
    endtask

    // Entered at the falling edge inside a FETCH cycle; leaves in the next FETCH.
    task automatic run_instr(input int iw, input logic dr, input logic dw, input logic rw,
                             input int dwait);
        int   high;
        int   n;
        bit   mem;
        exp_t e;
        mem = dr | dw;
        garbage_cu();
        for (int i = 0; i < iw; i++) begin
            ihit = 1'b0; dhit = 1'b1;
            check("fetch_imem", {31'd0, imemren}, 32'd1);
            check("fetch_noinstr", {31'd0, instren}, 32'd0);
            @(negedge clk); exp_cyc++;
        end
        dhit = 1'b0; ihit = 1'b1;
        #1 check("instrEN", {31'd0, instren}, 32'd1);
        @(negedge clk); exp_cyc++;
        ihit = 1'b0;
        cu_dren = dr; cu_dwen = dw; cu_regwrite = rw; cu_halt = 1'b0;
        e.regw  = rw;
        e.cyc   = exp_cyc + 2 + (mem ? dwait + 1 : 0);
        e.instr = exp_instr + 1;
        sb.push_back(e);
        check("decode_noimem", {31'd0, imemren}, 32'd0);
        @(negedge clk); exp_cyc++;
        garbage_cu();
        if (mem) begin
            high = 0;
            for (int i = 0; i <= dwait; i++) begin
                dhit = (i == dwait);
                high += int'(dr ? dmemren : dmemwen);
                check("mem_other", {31'd0, dr ? dmemwen : dmemren}, 32'd0);
                @(negedge clk); exp_cyc++;
            end
            dhit = 1'b0;
            check("mem_hold_cycles", high, dwait + 1);
            check("mem_drop", {30'd0, dmemren, dmemwen}, 32'd0);
        end
        n = 0;
        while (!pcen && n < 8) begin
            @(negedge clk); n++;
        end
        check("wb_pcEN", {31'd0, pcen}, 32'd1);
        e = sb.pop_front();
        check("wb_regWEN", {31'd0, regwen}, {31'd0, e.regw});
        @(negedge clk); exp_cyc++; exp_instr++;
        check("ret_cyc", cyc_count, e.cyc);
        check("ret_instr", instr_count, e.instr);
        check("ret_fetch", {30'd0, imemren, pcen}, 32'd2);
    endtask

    initial begin
        int hold_cyc;
        s_nrst = 1'b0;
        #12 s_nrst = 1'b1;

        // Add-type instruction: instrEN cycle 1, WB cycle 3, retired count 1.
        do_reset();
        run_instr(0, 1'b0, 1'b0, 1'b1, 0);
        check("add_err", {31'd0, err}, 32'd0);

        // Load with three wait cycles, then a store with regWrite clear.
        do_reset();
        run_instr(0, 1'b1, 1'b0, 1'b1, 3);
        check("load_cyc7", cyc_count, 32'd7);
        run_instr(2, 1'b0, 1'b1, 1'b0, 1);

        // Conflicting load+store decode.
        do_reset();
        ihit = 1'b1; @(negedge clk); ihit = 1'b0;
        cu_dren = 1'b1; cu_dwen = 1'b1; cu_regwrite = 1'b1;
        @(negedge clk);
        garbage_cu();
        for (int i = 0; i < 3; i++) begin
            check("ill_flags", {30'd0, err, halt}, 32'd3);
            check("ill_nostrobe", {29'd0, dmemren, dmemwen, imemren}, 32'd0);
            @(negedge clk);
        end

        // Halt decoded together with a load: halt wins, counters freeze.
        do_reset();
        ihit = 1'b1; @(negedge clk); ihit = 1'b0;
        cu_halt = 1'b1; cu_dren = 1'b1;
        @(negedge clk);
        garbage_cu();
        check("halt_flags", {30'd0, err, halt}, 32'd1);
        hold_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            ihit = 1'b1; dhit = 1'b1;
            hold_cyc += int'(dmemren | dmemwen | imemren | pcen);
            @(negedge clk);
        end
        check("halt_nostrobe", hold_cyc, 0);
        check("halt_cyc", cyc_count, 32'd2);
        check("halt_instr", instr_count, 32'd0);

        // Fetch timeout with no hit.
        do_reset();
        for (int i = 0; i < TO; i++) begin
            check("to_imem", {31'd0, imemren}, 32'd1);
            @(negedge clk);
        end
        check("to_flags", {29'd0, imemren, err, halt}, 32'd3);
        check("to_cyc", cyc_count, TO);

        // Hit in the last allowed wait cycle beats the timeout.
        do_reset();
        run_instr(TO - 1, 1'b0, 1'b0, 1'b1, 0);
        check("late_hit_err", {30'd0, err, halt}, 32'd0);

        // Asynchronous reset in the middle of a store.
        do_reset();
        ihit = 1'b1; @(negedge clk); ihit = 1'b0;
        cu_dwen = 1'b1;
        @(negedge clk);
        garbage_cu();
        dhit = 1'b0;
        check("ar_memwen", {31'd0, dmemwen}, 32'd1);
        #2 nrst = 1'b0;
        #1 check("ar_outs", {24'd0, imemren, dmemren, dmemwen, instren, pcen, regwen, halt, err}, 32'd0);
        check("ar_cnt", cyc_count | instr_count, 32'd0);
        @(negedge clk);
        cu_dren = 1'b0; cu_dwen = 1'b0; cu_regwrite = 1'b0; cu_halt = 1'b0;
        nrst = 1'b1;
        check("ar_idle", {31'd0, imemren}, 32'd0);
        @(negedge clk);
        check("ar_fetch", {31'd0, imemren}, 32'd1);
        check("ar_cyc0", cyc_count, 32'd0);

        // Narrow counters: many instructions later both stick at all-ones.
        check("sat_cyc", {29'd0, s_cyc}, 32'd7);
        check("sat_instr", {29'd0, s_instr_cnt}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Multicycle sequencer for a core's datapath and its shared instruction/data memory port. It steps each instruction through four phases: fetch, decode, memory and writeback. It holds the memory request strobes until the cache hit handshake arrives and gates PC, instruction-register and register-file writes. It also detects halt, illegal memory decodes and lost hits, and keeps saturating cycle and retired-instruction counters for the core.

## Interface
Parameters:
- CNT_W, default 32: width of both performance counters.
- TIMEOUT, default 255: maximum cycles a request may wait for its hit before the error path is taken. Minimum value is 1.

Ports:
- CLK, input, 1: single clock. All state changes on the rising edge.
- nRST, input, 1: asynchronous, active-low reset.
- ihit, input, 1: instruction memory hit. Valid only while imemREN=1.
- dhit, input, 1: data memory hit. Valid only while dmemREN or dmemWEN is 1.
- cu_dREN, input, 1: decoded load request from the control unit.
- cu_dWEN, input, 1: decoded store request from the control unit.
- cu_regWrite, input, 1: decoded register write enable from the control unit.
- cu_halt, input, 1: decoded halt from the control unit.
- imemREN, output, 1: instruction fetch request.
- dmemREN, output, 1: data read request.
- dmemWEN, output, 1: data write request.
- instrEN, output, 1: one-cycle load strobe for the instruction register.
- pcEN, output, 1: one-cycle PC update strobe.
- regWEN, output, 1: gated register-file write enable.
- halt, output, 1: sticky halt indication.
- err, output, 1: sticky error flag.
- cyc_count, output, CNT_W: cycles elapsed since leaving IDLE.
- instr_count, output, CNT_W: instructions retired.

## Operation
- States: IDLE, FETCH, DECODE, MEM, WB, HALT.
- All outputs are Moore outputs decoded from the registered state, except where a transition below gives a strobe.
- Reset state is IDLE. Every output is 0 and both counters are 0 in reset.
- IDLE: all strobes 0. Moves to FETCH unconditionally on the next edge.
- FETCH:
  - imemREN=1.
  - On ihit: instrEN=1 that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. The cu_* inputs are sampled here, and the sampled values are registered for use in MEM and WB. Priority order:
  - cu_halt → HALT.
  - cu_dREN and cu_dWEN both set → err=1, then HALT.
  - cu_dREN or cu_dWEN set → MEM.
  - Otherwise → WB.
- MEM:
  - dmemREN or dmemWEN follows the registered decode and is held steady until dhit.
  - On dhit: go to WB.
- WB:
  - pcEN=1 and regWEN=registered cu_regWrite for exactly one cycle.
  - instr_count increments, then go to FETCH.
- HALT:
  - halt=1. All strobes are 0.
  - Terminal. Only nRST leaves it.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments on each cycle spent there without a hit.
  - When it reaches TIMEOUT with still no hit: err=1, then HALT. The request strobe drops on the same edge.
- Counters:
  - cyc_count increments every cycle in any state other than IDLE and HALT.
  - Both counters saturate at all-ones and never wrap.
- Ignored inputs:
  - ihit is ignored outside FETCH.
  - dhit is ignored outside MEM.
  - cu_* inputs are ignored outside DECODE.

## Timing
- Minimum latency for a non-memory instruction is 3 cycles: FETCH with immediate ihit, DECODE, WB.
- Minimum latency for a load or store is 4 cycles.
- A hit is consumed on the edge that ends the cycle in which it is high. The next state is already non-requesting, so the request strobe drops the cycle after the hit cycle.
- instrEN is combinational on ihit while in FETCH: instrEN = (state==FETCH) & ihit.
- pcEN and regWEN are high only during the single WB cycle.
- Asynchronous reset asserted mid-MEM: dmemWEN and dmemREN drop immediately, without waiting for a clock edge. State returns to IDLE and halt, err and both counters clear.
- Timeout and hit arriving in the same cycle: the hit wins and there is no error.
- Halt and a memory op decoded together: halt wins. No memory access is issued and there is no error.

## Test plan
- Add-type instruction (cu_regWrite=1), ihit the first fetch cycle → instrEN at cycle 1, pcEN=regWEN=1 at cycle 3, instr_count=1, FETCH again at cycle 4.
- Load with dhit after 3 wait cycles → dmemREN high for exactly 4 cycles then low, regWEN=1 in WB, cyc_count=7 after retirement.
- Store with cu_regWrite=0 → dmemWEN held until dhit, regWEN=0 and pcEN=1 in WB.
- cu_dREN=cu_dWEN=1 in DECODE → err=1 and halt=1 one cycle later, no memory strobe ever asserted. cu_halt=1 → halt=1, err=0, and counters frozen for 20 further cycles.
- TIMEOUT=4 with ihit never asserted → imemREN high for 4 cycles, then err=halt=1. Separately, ihit in the 4th wait cycle → no error.
- nRST pulsed low mid-MEM → all outputs 0 without waiting for a clock edge. After release: one IDLE cycle, then imemREN=1 and counters restart at 0.
